// File: rtl/demux_1to2.sv
// 1-to-2 demultiplexer with registered outputs.
// The selected port takes D on the clock edge; the other port is cleared.
module demux_1to2 #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             S,
    output logic [WIDTH-1:0] mux_out_1,
    output logic [WIDTH-1:0] mux_out_2
);

    logic [WIDTH-1:0] next_1;
    logic [WIDTH-1:0] next_2;

    // Steer D to exactly one port; the unselected port is forced to zero.
    always_comb begin
        next_1 = '0;
        next_2 = '0;
        unique case (1'b1)
            !S: next_1 = D;
            S:  next_2 = D;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_out_1 <= '0;
            mux_out_2 <= '0;
        end else begin
            mux_out_1 <= next_1;
            mux_out_2 <= next_2;
        end
    end

endmodule

// File: tb/tb_demux_1to2.sv
// Self-checking bench for demux_1to2.
// Directed cases plus randomized traffic against a behavioural model.
module tb_demux_1to2;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] D = '0;
    logic         S = 1'b0;
    logic [W-1:0] mux_out_1;
    logic [W-1:0] mux_out_2;

    int checks = 0;
    int failures = 0;

    demux_1to2 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D         (D),
        .S         (S),
        .mux_out_1 (mux_out_1),
        .mux_out_2 (mux_out_2)
    );

    always #5 clk = ~clk;

    // Apply one word, then sample 1 time unit after the capturing edge.
    task automatic step(input logic [W-1:0] d, input logic s);
        D = d;
        S = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        D = 2'b11;
        S = 1'b1;
        #1;
        checks++;
        if (mux_out_1 !== 2'b00 || mux_out_2 !== 2'b00) begin
            failures++;
            $display("FAIL reset_async: out1=%0h out2=%0h expected 0 0",
                     mux_out_1, mux_out_2);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (mux_out_1 !== 2'b00 || mux_out_2 !== 2'b00) begin
                failures++;
                $display("FAIL reset_hold[%0d]: out1=%0h out2=%0h expected 0 0",
                         i, mux_out_1, mux_out_2);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] d_tab [4] = '{2'd1, 2'd1, 2'd0, 2'd0};
        logic         s_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] e1_tab[4] = '{2'd1, 2'd0, 2'd0, 2'd0};
        logic [W-1:0] e2_tab[4] = '{2'd0, 2'd1, 2'd0, 2'd0};
        for (int i = 0; i < 4; i++) begin
            step(d_tab[i], s_tab[i]);
            checks++;
            if (mux_out_1 !== e1_tab[i]) begin
                failures++;
                $display("FAIL basic[%0d] out1: got %0h expected %0h",
                         i, mux_out_1, e1_tab[i]);
            end
            checks++;
            if (mux_out_2 !== e2_tab[i]) begin
                failures++;
                $display("FAIL basic[%0d] out2: got %0h expected %0h",
                         i, mux_out_2, e2_tab[i]);
            end
        end
    endtask

    task automatic test_sweep();
        int e1;
        int e2;
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 2; s++) begin
                step(W'(d), s[0]);
                e1 = (s == 0) ? d : 0;
                e2 = (s == 1) ? d : 0;
                checks++;
                if (mux_out_1 !== W'(e1) || mux_out_2 !== W'(e2)) begin
                    failures++;
                    $display("FAIL sweep d=%0d s=%0d: out1=%0h out2=%0h expected %0h %0h",
                             d, s, mux_out_1, mux_out_2, e1, e2);
                end
            end
        end
    endtask

    // Model: each port carries D times its select weight, one cycle later.
    task automatic test_random();
        int d;
        int s;
        int e1;
        int e2;
        for (int i = 0; i < 200; i++) begin
            d = int'($urandom_range((1 << W) - 1, 0));
            s = int'($urandom_range(1, 0));
            step(W'(d), s[0]);
            e1 = d * (1 - s);
            e2 = d * s;
            checks++;
            if (mux_out_1 !== W'(e1) || mux_out_2 !== W'(e2)) begin
                failures++;
                $display("FAIL random[%0d] d=%0d s=%0d: out1=%0h out2=%0h expected %0h %0h",
                         i, d, s, mux_out_1, mux_out_2, e1, e2);
            end
            checks++;
            if (mux_out_1 != 0 && mux_out_2 != 0) begin
                failures++;
                $display("FAIL onehot[%0d]: out1=%0h out2=%0h both non-zero",
                         i, mux_out_1, mux_out_2);
            end
        end
    endtask

    task automatic test_reset_midstream();
        step(2'd3, 1'b1);
        checks++;
        if (mux_out_2 !== 2'd3 || mux_out_1 !== 2'd0) begin
            failures++;
            $display("FAIL mid_pre: out1=%0h out2=%0h expected 0 3",
                     mux_out_1, mux_out_2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mux_out_1 !== 2'd0 || mux_out_2 !== 2'd0) begin
            failures++;
            $display("FAIL mid_async: out1=%0h out2=%0h expected 0 0",
                     mux_out_1, mux_out_2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mux_out_1 !== 2'd0 || mux_out_2 !== 2'd0) begin
            failures++;
            $display("FAIL mid_hold: out1=%0h out2=%0h expected 0 0",
                     mux_out_1, mux_out_2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(2'd2, 1'b0);
        checks++;
        if (mux_out_1 !== 2'd2 || mux_out_2 !== 2'd0) begin
            failures++;
            $display("FAIL mid_release: out1=%0h out2=%0h expected 2 0",
                     mux_out_1, mux_out_2);
        end
    endtask

    task automatic test_back_to_back();
        step(2'd3, 1'b0);
        step(2'd3, 1'b1);
        checks++;
        if (mux_out_1 !== 2'd0 || mux_out_2 !== 2'd3) begin
            failures++;
            $display("FAIL b2b_switch: out1=%0h out2=%0h expected 0 3",
                     mux_out_1, mux_out_2);
        end
        step(2'd1, 1'b0);
        checks++;
        if (mux_out_1 !== 2'd1 || mux_out_2 !== 2'd0) begin
            failures++;
            $display("FAIL b2b_back: out1=%0h out2=%0h expected 1 0",
                     mux_out_1, mux_out_2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
